// File: rtl/seg_display_reader_if.sv
// ---------------------------------------------------------------------------
// seg_display_reader_if
//   Bundles the seven-segment display bus and the frame delivery handshake
//   used by seg_display_reader.
//
//   seg          segments A..G, active-low (seg[0] = A)
//   an           digit anodes, active-low, one low while a digit is driven
//   frame_valid  a complete frame is held on the frame outputs
//   frame_ready  consumer accepts the frame
//   frame_digits digit i occupies [4i+3:4i]
//   frame_blank  digit i was all-segments-off
//   frame_err    digit i carried an undefined pattern
//   overrun      sticky: a completed frame was dropped
//
//   slave  : the reader (samples the display, produces frames)
//   master : the environment (drives the display, consumes frames)
// ---------------------------------------------------------------------------
interface seg_display_reader_if #(
    parameter int NUM_DIGITS = 4
);
    logic [0:6]              seg;
    logic [NUM_DIGITS-1:0]   an;
    logic                    frame_valid;
    logic                    frame_ready;
    logic [4*NUM_DIGITS-1:0] frame_digits;
    logic [NUM_DIGITS-1:0]   frame_blank;
    logic [NUM_DIGITS-1:0]   frame_err;
    logic                    overrun;

    modport slave (
        input  seg,
        input  an,
        input  frame_ready,
        output frame_valid,
        output frame_digits,
        output frame_blank,
        output frame_err,
        output overrun
    );

    modport master (
        output seg,
        output an,
        output frame_ready,
        input  frame_valid,
        input  frame_digits,
        input  frame_blank,
        input  frame_err,
        input  overrun
    );
endinterface

// File: rtl/seg_display_reader.sv
// ---------------------------------------------------------------------------
// seg_display_reader
//   Reads a multiplexed, active-low seven-segment display bus, filters
//   transients, decodes every lit pattern back to a hex nibble (or a blank /
//   error flag) and delivers complete frames over a valid/ready handshake.
//
//   Parameters
//     NUM_DIGITS     number of multiplexed digits (>= 1)
//     STABLE_CYCLES  consecutive matching samples before a capture (>= 1)
//
//   Ports
//     clk    system clock
//     rst_n  asynchronous active-low reset
//     bus    seg_display_reader_if.slave: seg/an in, frame handshake out
//
//   All outputs are registered; there is no combinational input->output path.
// ---------------------------------------------------------------------------
module seg_display_reader #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    seg_display_reader_if.slave bus
);

    localparam int unsigned ND = NUM_DIGITS;
    localparam int unsigned SW = NUM_DIGITS + 7;
    localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);

    localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

    // input stage / stability filter
    logic [SW-1:0]   in_word;
    logic [SW-1:0]   samp;
    logic [6:0]      seg_p;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_n;
    int unsigned     nlow;
    logic            in_valid;
    logic            match;
    logic            capture;
    logic [ND-1:0]   dig_mask;

    // decoder
    logic [3:0]      dec_nib;
    logic            dec_blank;
    logic            dec_err;

    // working frame
    logic [4*ND-1:0] work_dig;
    logic [4*ND-1:0] work_dig_n;
    logic [ND-1:0]   work_blank;
    logic [ND-1:0]   work_blank_n;
    logic [ND-1:0]   work_err;
    logic [ND-1:0]   work_err_n;
    logic [ND-1:0]   seen;
    logic [ND-1:0]   seen_n;
    logic            complete;
    logic            publish_ok;

    // published frame
    logic            valid_q;
    logic            ovr_q;
    logic [4*ND-1:0] out_dig;
    logic [ND-1:0]   out_blank;
    logic [ND-1:0]   out_err;

    // seg is declared [0:6]; assigning it to [6:0] puts segment A in the MSB,
    // so the decode table below reads left-to-right as A..G.
    assign seg_p   = bus.seg;
    assign in_word = {bus.an, bus.seg};

    // A sample is valid only with exactly one anode low; dig_mask is then the
    // one-hot digit select.
    always_comb begin
        nlow     = 0;
        dig_mask = '0;
        for (int unsigned i = 0; i < ND; i++) begin
            if (!bus.an[i]) begin
                nlow        = nlow + 1;
                dig_mask[i] = 1'b1;
            end
        end
        in_valid = (nlow == 1);
    end

    assign match = (in_word == samp);

    // The counter tracks how many consecutive edges the current valid word
    // matched the previous sample. Capture fires only on the step into
    // saturation, so a steady pattern is captured exactly once.
    always_comb begin
        cnt_n = '0;
        if (match && in_valid) begin
            cnt_n = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
        end
    end

    assign capture = match && in_valid && (cnt == CNT_LAST);

    always_comb begin
        dec_nib   = 4'h0;
        dec_blank = 1'b0;
        dec_err   = 1'b0;
        case (seg_p)
            7'b0000001: dec_nib = 4'h0;
            7'b1001111: dec_nib = 4'h1;
            7'b0010010: dec_nib = 4'h2;
            7'b0000110: dec_nib = 4'h3;
            7'b1001100: dec_nib = 4'h4;
            7'b0100100: dec_nib = 4'h5;
            7'b0100000: dec_nib = 4'h6;
            7'b0001111: dec_nib = 4'h7;
            7'b0000000: dec_nib = 4'h8;
            7'b0001100: dec_nib = 4'h9;
            7'b0001000: dec_nib = 4'hA;
            7'b1100000: dec_nib = 4'hB;
            7'b0110001: dec_nib = 4'hC;
            7'b1000010: dec_nib = 4'hD;
            7'b0110000: dec_nib = 4'hE;
            7'b0111000: dec_nib = 4'hF;
            7'b1111111: dec_blank = 1'b1;
            default:    dec_err   = 1'b1;
        endcase
    end

    // Working slots with the current capture merged in; the same values feed
    // both the slot registers and the frame outputs on a publishing edge.
    always_comb begin
        work_dig_n   = work_dig;
        work_blank_n = work_blank;
        work_err_n   = work_err;
        seen_n       = seen;
        if (capture) begin
            for (int unsigned i = 0; i < ND; i++) begin
                if (dig_mask[i]) begin
                    work_dig_n[4*i +: 4] = dec_nib;
                    work_blank_n[i]      = dec_blank;
                    work_err_n[i]        = dec_err;
                    seen_n[i]            = 1'b1;
                end
            end
        end
    end

    // seen is cleared whenever a frame completes, so it can only reach
    // all-ones through a capture.
    assign complete   = capture && (&seen_n);
    assign publish_ok = !valid_q || bus.frame_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp       <= '1;
            cnt        <= '0;
            work_dig   <= '0;
            work_blank <= '0;
            work_err   <= '0;
            seen       <= '0;
            valid_q    <= 1'b0;
            ovr_q      <= 1'b0;
            out_dig    <= '0;
            out_blank  <= '0;
            out_err    <= '0;
        end else begin
            samp       <= in_word;
            cnt        <= cnt_n;
            work_dig   <= work_dig_n;
            work_blank <= work_blank_n;
            work_err   <= work_err_n;
            seen       <= complete ? '0 : seen_n;

            if (complete && publish_ok) begin
                valid_q   <= 1'b1;
                out_dig   <= work_dig_n;
                out_blank <= work_blank_n;
                out_err   <= work_err_n;
            end else if (valid_q && bus.frame_ready) begin
                valid_q <= 1'b0;
            end

            if (complete && !publish_ok) begin
                ovr_q <= 1'b1;
            end
        end
    end

    assign bus.frame_valid  = valid_q;
    assign bus.frame_digits = out_dig;
    assign bus.frame_blank  = out_blank;
    assign bus.frame_err    = out_err;
    assign bus.overrun      = ovr_q;

endmodule

// File: tb/tb_seg_display_reader.sv
module tb_seg_display_reader;

    localparam int ND = 4;
    localparam int SC = 4;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    seg_display_reader_if #(.NUM_DIGITS(ND)) bus ();

    seg_display_reader #(
        .NUM_DIGITS    (ND),
        .STABLE_CYCLES (SC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int    n_checks = 0;
    int    n_fail   = 0;
    int    n_pulse  = 0;
    string phase    = "por";

    logic [6:0] pat [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };
    localparam logic [6:0] BLANK = 7'h7F;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Capture rule: the last SC+1 input words are identical and valid, and the
    // word before that window (if any) differs.
    logic [ND+6:0] hist [$];
    logic [3:0]    w_dig   [ND];
    logic          w_blank [ND];
    logic          w_err   [ND];
    bit            seen    [ND];
    logic          m_valid;
    logic          m_ovr;
    logic [15:0]   m_dig;
    logic [ND-1:0] m_blank;
    logic [ND-1:0] m_err;

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < ND; i++) begin
            w_dig[i] = 4'h0; w_blank[i] = 1'b0; w_err[i] = 1'b0; seen[i] = 1'b0;
        end
        m_valid = 1'b0; m_ovr = 1'b0; m_dig = '0; m_blank = '0; m_err = '0;
    endtask

    task automatic model_step(input logic [ND-1:0] a, input logic [6:0] s, input logic rdy);
        logic [ND+6:0] cur;
        int            lows;
        int            d;
        bit            cap;
        bit            all;
        cur = {a, s};
        hist.push_back(cur);
        if (hist.size() > SC + 2) void'(hist.pop_front());
        lows = 0;
        d    = 0;
        for (int i = 0; i < ND; i++) if (!a[i]) begin lows++; d = i; end
        cap = (lows == 1) && (hist.size() >= SC + 1);
        if (cap) begin
            for (int k = 1; k <= SC; k++)
                if (hist[hist.size() - 1 - k] != cur) cap = 0;
            if (hist.size() == SC + 2 && hist[0] == cur) cap = 0;
        end
        if (cap) begin
            w_dig[d] = 4'h0; w_blank[d] = 1'b0; w_err[d] = 1'b1;
            if (s == BLANK) begin
                w_blank[d] = 1'b1; w_err[d] = 1'b0;
            end else begin
                for (int v = 0; v < 16; v++)
                    if (pat[v] == s) begin w_dig[d] = 4'(v); w_err[d] = 1'b0; end
            end
            seen[d] = 1'b1;
        end
        all = cap;
        for (int i = 0; i < ND; i++) all = all && seen[i];
        if (all) begin
            for (int i = 0; i < ND; i++) seen[i] = 1'b0;
            if (!m_valid || rdy) begin
                m_valid = 1'b1;
                for (int i = 0; i < ND; i++) begin
                    m_dig[4*i +: 4] = w_dig[i];
                    m_blank[i]      = w_blank[i];
                    m_err[i]        = w_err[i];
                end
            end else begin
                m_ovr = 1'b1;
            end
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
    endtask

    // ---------------- stimulus helpers (called at negedge) ----------------
    task automatic tick(input logic [ND-1:0] a, input logic [6:0] s);
        bus.an  = a;
        bus.seg = s;
        model_step(a, s, bus.frame_ready);
        @(posedge clk);
        #1;
        check_eq({phase, ".valid"},   32'(bus.frame_valid),  32'(m_valid));
        check_eq({phase, ".digits"},  32'(bus.frame_digits), 32'(m_dig));
        check_eq({phase, ".blank"},   32'(bus.frame_blank),  32'(m_blank));
        check_eq({phase, ".err"},     32'(bus.frame_err),    32'(m_err));
        check_eq({phase, ".overrun"}, 32'(bus.overrun),      32'(m_ovr));
        if (bus.frame_valid === 1'b1) n_pulse++;
        @(negedge clk);
    endtask

    task automatic hold(input int d, input logic [6:0] s, input int n);
        logic [ND-1:0] a;
        a = '1;
        a[d] = 1'b0;
        repeat (n) tick(a, s);
    endtask

    task automatic idle(input int n);
        repeat (n) tick('1, BLANK);
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, ".valid0"},   32'(bus.frame_valid),  32'd0);
        check_eq({tag, ".digits0"},  32'(bus.frame_digits), 32'd0);
        check_eq({tag, ".blank0"},   32'(bus.frame_blank),  32'd0);
        check_eq({tag, ".err0"},     32'(bus.frame_err),    32'd0);
        check_eq({tag, ".overrun0"}, 32'(bus.overrun),      32'd0);
    endtask

    // Asynchronous reset asserted between edges, held across two edges.
    task automatic do_reset(input string tag);
        #2 rst_n = 1'b0;
        #1 check_zero(tag);
        @(posedge clk);
        @(posedge clk);
        #1 check_zero(tag);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [ND-1:0] ra;
        logic [6:0]    rs;
        int            rl;
        int            kind;

        rst_n           = 1'b0;
        bus.an          = '1;
        bus.seg         = BLANK;
        bus.frame_ready = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        check_zero("por");
        rst_n = 1'b1;

        // Basic frame 1,A,F,0 on digits 3..0
        phase = "tp1"; n_pulse = 0;
        hold(3, pat[1], 8); hold(2, pat[10], 8); hold(1, pat[15], 8); hold(0, pat[0], 8);
        check_eq("tp1.digits_k", 32'(bus.frame_digits), 32'h1AF0);
        check_eq("tp1.blank_k",  32'(bus.frame_blank),  32'h0);
        check_eq("tp1.err_k",    32'(bus.frame_err),    32'h0);
        check_eq("tp1.pulses",   32'(n_pulse),          32'd1);

        // Filter boundary: 4 edges is not enough, 5 edges captures
        phase = "tp2"; n_pulse = 0;
        idle(2);
        hold(0, pat[3], 4);
        hold(1, pat[5], 8); hold(2, pat[6], 8); hold(3, pat[7], 8);
        check_eq("tp2.no_frame", 32'(n_pulse), 32'd0);
        hold(0, pat[3], 5);
        check_eq("tp2.digits_k", 32'(bus.frame_digits), 32'h7653);
        check_eq("tp2.pulses",   32'(n_pulse),          32'd1);

        // Glitch inside a steady 8, then two anodes low
        phase = "tp3"; n_pulse = 0;
        idle(2);
        hold(2, pat[8], 3); hold(2, 7'b1011111, 1); hold(2, pat[8], 3);
        repeat (10) tick(4'b0011, pat[8]);
        hold(3, pat[1], 8); hold(1, pat[3], 8); hold(0, pat[4], 8);
        check_eq("tp3.no_frame", 32'(n_pulse), 32'd0);
        hold(2, pat[14], 8);
        check_eq("tp3.digits_k", 32'(bus.frame_digits), 32'h1E34);
        check_eq("tp3.pulses",   32'(n_pulse),          32'd1);

        // Blank and error digits
        phase = "tp4";
        hold(3, BLANK, 8); hold(2, pat[8], 8); hold(1, 7'b0111111, 8); hold(0, pat[12], 8);
        check_eq("tp4.digits_k", 32'(bus.frame_digits), 32'h080C);
        check_eq("tp4.blank_k",  32'(bus.frame_blank),  32'b1000);
        check_eq("tp4.err_k",    32'(bus.frame_err),    32'b0010);

        // Backpressure: second frame dropped, overrun sticky
        phase = "tp5";
        bus.frame_ready = 1'b0;
        hold(3, pat[9], 8); hold(2, pat[8], 8); hold(1, pat[7], 8); hold(0, pat[6], 8);
        check_eq("tp5.held_valid", 32'(bus.frame_valid),  32'd1);
        check_eq("tp5.first",      32'(bus.frame_digits), 32'h9876);
        check_eq("tp5.ovr_before", 32'(bus.overrun),      32'd0);
        hold(3, pat[2], 8); hold(2, pat[2], 8); hold(1, pat[2], 8); hold(0, pat[2], 8);
        check_eq("tp5.still",      32'(bus.frame_digits), 32'h9876);
        check_eq("tp5.ovr_after",  32'(bus.overrun),      32'd1);
        bus.frame_ready = 1'b1;
        idle(1);
        check_eq("tp5.drained",    32'(bus.frame_valid),  32'd0);

        // Reset with a partial frame captured
        phase = "tp6"; n_pulse = 0;
        hold(3, pat[1], 8); hold(2, pat[2], 8);
        do_reset("tp6.rst");
        hold(1, pat[12], 8); hold(0, pat[13], 8);
        check_eq("tp6.no_frame", 32'(n_pulse), 32'd0);
        hold(3, pat[10], 8); hold(2, pat[11], 8);
        check_eq("tp6.digits_k", 32'(bus.frame_digits), 32'hABCD);
        check_eq("tp6.pulses",   32'(n_pulse),          32'd1);

        // Randomized traffic against the model
        phase = "rand";
        for (int it = 0; it < 300; it++) begin
            kind = $urandom_range(0, 9);
            ra   = '1;
            ra[$urandom_range(0, ND - 1)] = 1'b0;
            rs   = pat[$urandom_range(0, 15)];
            if (kind == 7) rs = BLANK;
            if (kind == 8) rs = 7'($urandom);
            if (kind == 9) ra = ND'($urandom);
            rl = $urandom_range(1, 8);
            repeat (rl) begin
                bus.frame_ready = ($urandom_range(0, 3) != 0);
                tick(ra, rs);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
